// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the Genius game datapath blocks.
//   ST_IDLE/ST_PLAY/ST_WIN/ST_LOSE : 2-bit state encodings
//   GAME_WIDTH                     : default width of round/target values
//   GAME_MAX_ROUNDS                : default upper clamp for the target
//   state_t                        : enum built on the state encodings
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;
  localparam logic [1:0] ST_LOSE = 2'd3;

  localparam int GAME_WIDTH      = 4;
  localparam int GAME_MAX_ROUNDS = 15;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PLAY = ST_PLAY,
    WIN  = ST_WIN,
    LOSE = ST_LOSE
  } state_t;

endpackage

// File: rtl/round_tracker_if.sv
// ---------------------------------------------------------------------------
// round_tracker_if
// Groups the control strobes from the game FSM and the score/display outputs.
//   start, E, fail : one-cycle strobes from game control
//   data           : target round count, sampled on start
//   ROUND, BEST    : current round count and best score
//   tc_o, lose_o   : win / loss flags
//   busy_o         : high while a game is in progress
// master = game control side, slave = round_tracker.
// ---------------------------------------------------------------------------
interface round_tracker_if
  import game_pkg::*;
#(
  parameter int WIDTH = GAME_WIDTH
);

  logic             start;
  logic             E;
  logic             fail;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] ROUND;
  logic [WIDTH-1:0] BEST;
  logic             tc_o;
  logic             lose_o;
  logic             busy_o;

  modport master (
    output start, E, fail, data,
    input  ROUND, BEST, tc_o, lose_o, busy_o
  );

  modport slave (
    input  start, E, fail, data,
    output ROUND, BEST, tc_o, lose_o, busy_o
  );

endinterface

// File: rtl/round_tracker.sv
// ---------------------------------------------------------------------------
// round_tracker
// Counts completed rounds in the current Genius game, flags a win when the
// loaded target is reached or a loss on a player error, and keeps the best
// score reached at any game end since reset.
//   clk  : system clock, rising edge
//   R    : asynchronous active-high reset
//   bus  : round_tracker_if.slave (start/E/fail/data in,
//          ROUND/BEST/tc_o/lose_o/busy_o out, all outputs registered)
// Parameters: WIDTH, MAX_ROUNDS (target clamp), TC_MODE (0 level, 1 pulse).
// ---------------------------------------------------------------------------
module round_tracker
  import game_pkg::*;
#(
  parameter int WIDTH      = GAME_WIDTH,
  parameter int MAX_ROUNDS = GAME_MAX_ROUNDS,
  parameter int TC_MODE    = 0
) (
  input  logic            clk,
  input  logic            R,
  round_tracker_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_TARGET = WIDTH'(MAX_ROUNDS);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] round_q, round_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic             tc_q, tc_d;
  logic             lose_q, lose_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] roundInc;
  logic             enteringEnd;

  // A zero target would make a game unwinnable, so it is raised to one;
  // oversize targets are capped so the counter can never wrap.
  function automatic logic [WIDTH-1:0] clampTarget(input logic [WIDTH-1:0] d);
    if (d == '0)             return ONE;
    else if (d > MAX_TARGET) return MAX_TARGET;
    else                     return d;
  endfunction

  assign roundInc = round_q + ONE;

  // Next-state logic: start overrides everything, then fail beats E in PLAY.
  // BEST and the flags are computed from the next state so they appear
  // together with the state change.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    round_d  = round_q;
    best_d   = best_q;

    if (bus.start) begin
      target_d = clampTarget(bus.data);
      round_d  = '0;
      state_d  = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.fail) begin
            state_d = LOSE;
          end else if (bus.E) begin
            if (roundInc == target_q) begin
              round_d = target_q;
              state_d = WIN;
            end else begin
              round_d = roundInc;
            end
          end
        end
        default: ;
      endcase
    end

    enteringEnd = (state_q == PLAY) && ((state_d == WIN) || (state_d == LOSE));
    if (enteringEnd && (round_d > best_q)) begin
      best_d = round_d;
    end

    // Pulse mode only raises the flag on the cycle of entry; the end states
    // are only reachable from PLAY, so "previous state differs" is entry.
    if (TC_MODE == 1) begin
      tc_d   = (state_d == WIN)  && (state_q != WIN);
      lose_d = (state_d == LOSE) && (state_q != LOSE);
    end else begin
      tc_d   = (state_d == WIN);
      lose_d = (state_d == LOSE);
    end
    busy_d = (state_d == PLAY);
  end

  // State and output registers; reset clears the best score too.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q  <= IDLE;
      target_q <= '0;
      round_q  <= '0;
      best_q   <= '0;
      tc_q     <= 1'b0;
      lose_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      round_q  <= round_d;
      best_q   <= best_d;
      tc_q     <= tc_d;
      lose_q   <= lose_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ROUND  = round_q;
  assign bus.BEST   = best_q;
  assign bus.tc_o   = tc_q;
  assign bus.lose_o = lose_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_round_tracker.sv
// ---------------------------------------------------------------------------
// tb_round_tracker
// Directed bench for round_tracker. Three instances share one stimulus:
//   dutA : TC_MODE=0, MAX_ROUNDS=15
//   dutB : TC_MODE=1, MAX_ROUNDS=15
//   dutC : TC_MODE=0, MAX_ROUNDS=10
// ---------------------------------------------------------------------------
module tb_round_tracker;

  logic       clk = 1'b0;
  logic       R   = 1'b1;
  logic       start = 1'b0;
  logic       E     = 1'b0;
  logic       fail  = 1'b0;
  logic [3:0] data  = 4'd0;

  int compared   = 0;
  int mismatched = 0;

  round_tracker_if #(.WIDTH(4)) ifA ();
  round_tracker_if #(.WIDTH(4)) ifB ();
  round_tracker_if #(.WIDTH(4)) ifC ();

  assign ifA.start = start;
  assign ifA.E     = E;
  assign ifA.fail  = fail;
  assign ifA.data  = data;
  assign ifB.start = start;
  assign ifB.E     = E;
  assign ifB.fail  = fail;
  assign ifB.data  = data;
  assign ifC.start = start;
  assign ifC.E     = E;
  assign ifC.fail  = fail;
  assign ifC.data  = data;

  round_tracker #(.WIDTH(4), .MAX_ROUNDS(15), .TC_MODE(0)) dutA (.clk(clk), .R(R), .bus(ifA));
  round_tracker #(.WIDTH(4), .MAX_ROUNDS(15), .TC_MODE(1)) dutB (.clk(clk), .R(R), .bus(ifB));
  round_tracker #(.WIDTH(4), .MAX_ROUNDS(10), .TC_MODE(0)) dutC (.clk(clk), .R(R), .bus(ifC));

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of strobes around a rising edge; outputs are settled
  // #1 after that edge when the task returns.
  task automatic applyStimulus(input logic s, input logic e, input logic f,
                               input logic [3:0] d);
    @(negedge clk);
    start = s;
    E     = e;
    fail  = f;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    E     = 1'b0;
    fail  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    // Reset state
    #2;
    checkOutput("rst_round", ifA.ROUND, 0);
    checkOutput("rst_best", ifA.BEST, 0);
    checkOutput("rst_tc", ifA.tc_o, 0);
    checkOutput("rst_lose", ifA.lose_o, 0);
    checkOutput("rst_busy", ifA.busy_o, 0);
    @(negedge clk);
    R = 1'b0;

    // Game 1: target 4, four E strobes
    applyStimulus(1, 0, 0, 4'd4);
    checkOutput("g1_start_round", ifA.ROUND, 0);
    checkOutput("g1_start_busy", ifA.busy_o, 1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 4'd0);
      checkOutput("g1_round", ifA.ROUND, i);
      checkOutput("g1_tc_low", ifA.tc_o, 0);
    end
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g1_win_round", ifA.ROUND, 4);
    checkOutput("g1_win_tcA", ifA.tc_o, 1);
    checkOutput("g1_win_tcB", ifB.tc_o, 1);
    checkOutput("g1_win_best", ifA.BEST, 4);
    checkOutput("g1_win_busy", ifA.busy_o, 0);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("g1_hold_tcA", ifA.tc_o, 1);
    checkOutput("g1_hold_tcB", ifB.tc_o, 0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g1_extraE_round", ifA.ROUND, 4);

    // Game 2: target 6, two E then fail
    applyStimulus(1, 0, 0, 4'd6);
    checkOutput("g2_start_tc", ifA.tc_o, 0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g2_round", ifA.ROUND, 2);
    applyStimulus(0, 0, 1, 4'd0);
    checkOutput("g2_lose", ifA.lose_o, 1);
    checkOutput("g2_lose_round", ifA.ROUND, 2);
    checkOutput("g2_lose_best", ifA.BEST, 4);
    checkOutput("g2_loseB_pulse", ifB.lose_o, 1);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("g2_loseB_clear", ifB.lose_o, 0);
    checkOutput("g2_loseA_hold", ifA.lose_o, 1);

    // Game 3: target 3, pulse mode flag lasts one cycle
    applyStimulus(1, 0, 0, 4'd3);
    checkOutput("g3_start_lose", ifA.lose_o, 0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g3_tcB_pulse", ifB.tc_o, 1);
    checkOutput("g3_roundB", ifB.ROUND, 3);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("g3_tcB_clear", ifB.tc_o, 0);
    checkOutput("g3_bestB", ifB.BEST, 4);

    // Game 4: data 0 clamps to target 1
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g4_round", ifA.ROUND, 1);
    checkOutput("g4_tc", ifA.tc_o, 1);

    // Game 5: data 15, dutC clamps to 10
    applyStimulus(1, 0, 0, 4'd15);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 1, 0, 4'd0);
    end
    checkOutput("g5_roundC9", ifC.ROUND, 9);
    checkOutput("g5_tcC9", ifC.tc_o, 0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g5_roundC10", ifC.ROUND, 10);
    checkOutput("g5_tcC10", ifC.tc_o, 1);
    checkOutput("g5_bestC", ifC.BEST, 10);
    checkOutput("g5_busyA10", ifA.busy_o, 1);
    checkOutput("g5_tcA10", ifA.tc_o, 0);
    for (int i = 11; i <= 15; i++) begin
      applyStimulus(0, 1, 0, 4'd0);
    end
    checkOutput("g5_roundA15", ifA.ROUND, 15);
    checkOutput("g5_tcA15", ifA.tc_o, 1);
    checkOutput("g5_bestA15", ifA.BEST, 15);
    checkOutput("g5_roundC_hold", ifC.ROUND, 10);

    // Game 6: start+E same cycle, then fail+E same cycle
    applyStimulus(1, 1, 0, 4'd5);
    checkOutput("g6_startE_round", ifA.ROUND, 0);
    checkOutput("g6_startE_busy", ifA.busy_o, 1);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 1, 4'd0);
    checkOutput("g6_failE_lose", ifA.lose_o, 1);
    checkOutput("g6_failE_round", ifA.ROUND, 2);

    // Game 7: restart mid-PLAY with a new target
    applyStimulus(1, 0, 0, 4'd7);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g7_round3", ifA.ROUND, 3);
    applyStimulus(1, 0, 0, 4'd2);
    checkOutput("g7_restart_round", ifA.ROUND, 0);
    checkOutput("g7_restart_tc", ifA.tc_o, 0);
    checkOutput("g7_restart_lose", ifA.lose_o, 0);
    checkOutput("g7_restart_best", ifA.BEST, 15);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("g7_newtarget_tc", ifA.tc_o, 1);
    checkOutput("g7_newtarget_round", ifA.ROUND, 2);

    // Reset mid-PLAY at ROUND 3, checked before the next clock edge
    applyStimulus(1, 0, 0, 4'd8);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("r_pre_round", ifA.ROUND, 3);
    @(negedge clk);
    R = 1'b1;
    #1;
    checkOutput("r_async_round", ifA.ROUND, 0);
    checkOutput("r_async_best", ifA.BEST, 0);
    checkOutput("r_async_busy", ifA.busy_o, 0);
    checkOutput("r_async_bestC", ifC.BEST, 0);
    @(negedge clk);
    R = 1'b0;

    // After reset: E ignored in IDLE, BEST rebuilt from zero
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("idle_E_round", ifA.ROUND, 0);
    checkOutput("idle_E_busy", ifA.busy_o, 0);
    applyStimulus(1, 0, 0, 4'd4);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 0, 1, 4'd0);
    checkOutput("post_lose", ifA.lose_o, 1);
    checkOutput("post_best", ifA.BEST, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/round_tracker.md
Name: round_tracker

Overview:
Parametrised round counter for the Genius game datapath. It counts the sequences the player completes in the current game and compares the count against a loaded target. It flags a win on the target or a loss on a player error, and keeps a best-score register across games. It sits between the game-control FSM (start, E, fail strobes) and the display and score logic (ROUND, BEST, tc_o, lose_o).

Parameters:
WIDTH, 4, width of data, target, ROUND and BEST.
MAX_ROUNDS, 15, upper clamp for the loaded target; must be in 1 to 2**WIDTH-1.
TC_MODE, 0, 0 = tc_o/lose_o held high while in WIN/LOSE; 1 = one-cycle pulse on entry.

Ports:
clk  in  1  system clock, rising edge.
R  in  1  asynchronous active-high reset.
start  in  1  one-cycle strobe: latch target from data, begin new game.
E  in  1  one-cycle strobe: player completed one round.
fail  in  1  one-cycle strobe: player entered a wrong colour.
data  in  WIDTH  target round count, sampled only on start.
ROUND  out  WIDTH  rounds completed in the current game.
BEST  out  WIDTH  highest ROUND reached at any game end since reset.
tc_o  out  1  win flag; form set by TC_MODE.
lose_o  out  1  loss flag; form set by TC_MODE.
busy_o  out  1  high while in PLAY.

Behaviour:
- Reset (R=1, asynchronous): state=IDLE; internal target=0; ROUND=0, BEST=0, tc_o=0, lose_o=0, busy_o=0. These values hold while R is high.
- All other updates occur on posedge clk. All outputs are registered.
- States: IDLE, PLAY, WIN, LOSE.
- Priority within one cycle: start > fail > E.
- start, in any state including mid-game:
  - target = clamp(data): 0 becomes 1; values above MAX_ROUNDS become MAX_ROUNDS.
  - ROUND=0, tc_o=0, lose_o=0, next state PLAY. BEST is unchanged.
  - E or fail in the same cycle is ignored.
- PLAY:
  - fail -> LOSE; ROUND holds.
  - E with ROUND+1 == target -> ROUND=target, next state WIN.
  - E otherwise -> ROUND=ROUND+1, stay in PLAY.
  - No strobe -> hold.
- WIN and LOSE:
  - Hold ROUND until start.
  - Ignore E and fail.
- E and fail are ignored in IDLE.
- ROUND can never exceed target, so the counter does not wrap.
- BEST update: in the cycle the FSM enters WIN or LOSE, BEST = max(BEST, final ROUND). The new BEST is visible the cycle after entry, together with tc_o/lose_o.
- tc_o:
  - TC_MODE=0: high in every cycle state==WIN.
  - TC_MODE=1: high exactly one cycle, the first cycle in WIN.
- lose_o: same rules as tc_o, applied to LOSE.
- busy_o = (state==PLAY).
- Latency: the E/fail strobe at edge N produces outputs visible after edge N.
- Reset mid-game clears BEST as well; no score survives R.

Decomposition:
- Shared package game_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_PLAY=2'd1, ST_WIN=2'd2, ST_LOSE=2'd3;
  - default WIDTH and MAX_ROUNDS constants used by the other Genius blocks.
- No sub-module: the FSM, counter, clamp and max-compare fit in one module.

Test Plan:
- R pulse mid-PLAY with ROUND=3, BEST=5 -> all outputs 0 immediately, before the next clk edge; state IDLE.
- start with data=4, then 4 E strobes, TC_MODE=0 -> ROUND 1,2,3,4. tc_o rises after the 4th E and stays high; BEST=4; busy_o low. A 5th E leaves ROUND=4.
- start with data=6, 2 E, then fail -> lose_o=1, ROUND=2, BEST stays 4. Then start with data=3, 3 E, TC_MODE=1 -> tc_o high exactly one cycle; BEST=4.
- start with data=0 -> target 1; one E gives a win. start with data=15 and MAX_ROUNDS=10 -> the win comes at ROUND=10.
- Same-cycle start+E gives ROUND=0 in PLAY. Same-cycle fail+E in PLAY with ROUND=2 gives LOSE with ROUND=2.
- start issued mid-PLAY at ROUND=3 -> ROUND=0, tc_o=0, lose_o=0, BEST unchanged; the new target is taken from data.
